ram_bus_arbiter: RTL and testbench

- Shares the single-port data RAM between two requesters:
  - master 0: CPU load/store port.
  - master 1: debug/loader port used to preload or inspect RAM.
- Sits between the requesters and the memory_ram instance.
- Sequences each access as a request/acknowledge transaction and chooses between the masters with round-robin arbitration plus an optional bus lock.
- Drives the RAM CE/RD/WR strobes so they are active only during the access phase.

---
 rtl/ram_bus_arbiter_if.sv | 28 ++
 rtl/ram_bus_arbiter.sv | 114 +++++++++++
 tb/tb_ram_bus_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ram_bus_arbiter_if.sv
// ram_bus_arbiter_if: bundles both requester ports and the RAM port of the arbiter
//   slave  : arbiter view (requests and RAM read data in; acks, RAM strobes, grant out)
//   master : environment view (requesters plus RAM)
interface ram_bus_arbiter_if #(parameter int AW = 8, parameter int DW = 32);
   logic          iM0_REQ, iM0_WR, iM0_LOCK, oM0_ACK;
   logic [AW-1:0] iM0_ADDR;
   logic [DW-1:0] iM0_WDATA, oM0_RDATA;
   logic          iM1_REQ, iM1_WR, iM1_LOCK, oM1_ACK;
   logic [AW-1:0] iM1_ADDR;
   logic [DW-1:0] iM1_WDATA, oM1_RDATA;
   logic          oRAM_CE, oRAM_RD, oRAM_WR;
   logic [AW-1:0] oRAM_ADDR;
   logic [DW-1:0] oRAM_DATA, iRAM_DATA;
   logic [1:0]    oGNT;
   logic          oBUSY;
   modport slave (
      input  iM0_REQ, iM0_WR, iM0_LOCK, iM0_ADDR, iM0_WDATA,
      input  iM1_REQ, iM1_WR, iM1_LOCK, iM1_ADDR, iM1_WDATA, iRAM_DATA,
      output oM0_ACK, oM0_RDATA, oM1_ACK, oM1_RDATA,
      output oRAM_CE, oRAM_RD, oRAM_WR, oRAM_ADDR, oRAM_DATA, oGNT, oBUSY
   );
   modport master (
      output iM0_REQ, iM0_WR, iM0_LOCK, iM0_ADDR, iM0_WDATA,
      output iM1_REQ, iM1_WR, iM1_LOCK, iM1_ADDR, iM1_WDATA, iRAM_DATA,
      input  oM0_ACK, oM0_RDATA, oM1_ACK, oM1_RDATA,
      input  oRAM_CE, oRAM_RD, oRAM_WR, oRAM_ADDR, oRAM_DATA, oGNT, oBUSY
   );
endinterface

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: round-robin arbiter with bus lock sharing one single-port RAM between two masters
//   iCLK : clock, rising edge
//   iRST : asynchronous active-low reset
//   bus  : requester ports, RAM strobes/address/data, grant and busy (slave modport)
module ram_bus_arbiter #(
   parameter int AW     = 8,
   parameter int DW     = 32,
   parameter int RD_LAT = 0
) (
   input logic              iCLK,
   input logic              iRST,
   ram_bus_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;
   state_t        state_q, state_d;
   logic          owner_q, owner_d, wr_q, wr_d, lock_q, lock_d, last_q, last_d;
   logic [1:0]    gnt_q, gnt_d, cnt_q, cnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic [1:0]    req, lck;
   logic          sel, grant;
   assign req   = {bus.iM1_REQ, bus.iM0_REQ};
   assign lck   = {bus.iM1_LOCK, bus.iM0_LOCK};
   // a held lock pins the choice to the owner; otherwise a tie goes to the master not served last
   assign sel   = lock_q ? owner_q : (&req ? ~last_q : req[1]);
   assign grant = lock_q ? req[owner_q] : |req;
   always_ff @(posedge iCLK or negedge iRST)
      if (!iRST) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         wr_q    <= 1'b0;
         lock_q  <= 1'b0;
         last_q  <= 1'b1;
         gnt_q   <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         wr_q    <= wr_d;
         lock_q  <= lock_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      wr_d    = wr_q;
      lock_d  = lock_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      unique case (state_q)
         IDLE:
            if (grant) begin
               state_d = ACCESS;
               owner_d = sel;
               wr_d    = sel ? bus.iM1_WR : bus.iM0_WR;
               addr_d  = sel ? bus.iM1_ADDR : bus.iM0_ADDR;
               wdata_d = sel ? bus.iM1_WDATA : bus.iM0_WDATA;
               gnt_d   = sel ? 2'b10 : 2'b01;
            end else if (lock_q && !lck[owner_q]) begin
               lock_d = 1'b0;
               gnt_d  = 2'b00;
            end
         ACCESS:
            if (wr_q) begin
               state_d = ACK;
               rdata_d = '0;
            end else if (RD_LAT == 0) begin
               state_d = ACK;
               rdata_d = bus.iRAM_DATA;
            end else begin
               state_d = WAIT;
               cnt_d   = 2'(RD_LAT - 1);
            end
         WAIT:
            if (cnt_q == 2'd0) begin
               state_d = ACK;
               rdata_d = bus.iRAM_DATA;
            end else
               cnt_d = cnt_q - 2'd1;
         ACK: begin
            state_d = IDLE;
            last_d  = owner_q;
            lock_d  = lck[owner_q];
            gnt_d   = lck[owner_q] ? gnt_q : 2'b00;
         end
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      bus.oRAM_CE   = state_q == ACCESS || state_q == WAIT;
      bus.oRAM_RD   = (state_q == ACCESS || state_q == WAIT) && !wr_q;
      bus.oRAM_WR   = state_q == ACCESS && wr_q;
      bus.oRAM_ADDR = addr_q;
      bus.oRAM_DATA = wdata_q;
      bus.oM0_ACK   = state_q == ACK && !owner_q;
      bus.oM1_ACK   = state_q == ACK && owner_q;
      bus.oM0_RDATA = rdata_q;
      bus.oM1_RDATA = rdata_q;
      bus.oGNT      = gnt_q;
      bus.oBUSY     = state_q != IDLE;
   end
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// tb_ram_bus_arbiter: directed checks of ram_bus_arbiter with RD_LAT=0 and RD_LAT=2 builds
module tb_ram_bus_arbiter;
   logic iCLK = 1'b0;
   logic iRST;
   int   n_cmp, n_err;
   ram_bus_arbiter_if #(.AW(8), .DW(32)) b0 ();
   ram_bus_arbiter_if #(.AW(8), .DW(32)) b2 ();
   ram_bus_arbiter #(.AW(8), .DW(32), .RD_LAT(0)) dut0 (.iCLK(iCLK), .iRST(iRST), .bus(b0));
   ram_bus_arbiter #(.AW(8), .DW(32), .RD_LAT(2)) dut2 (.iCLK(iCLK), .iRST(iRST), .bus(b2));
   always #5 iCLK = ~iCLK;
   logic [31:0] mem0 [256] = '{default: '0};
   logic [31:0] mem2 [256] = '{default: '0};
   logic [1:0]  rd_cnt = 2'd0;
   always @(posedge iCLK)
      if (!iRST) begin
         mem0[1] <= 32'h1111_1111;
         mem0[2] <= 32'h2222_2222;
      end else if (b0.oRAM_CE && b0.oRAM_WR)
         mem0[b0.oRAM_ADDR] <= b0.oRAM_DATA;
   always @(posedge iCLK)
      if (!iRST) mem2[5] <= 32'h1234_5678;
   always @(posedge iCLK) rd_cnt <= b2.oRAM_RD ? rd_cnt + 2'd1 : 2'd0;
   assign b0.iRAM_DATA = (b0.oRAM_CE && b0.oRAM_RD) ? mem0[b0.oRAM_ADDR] : 32'hBAD0_BAD0;
   // slow RAM: data only valid on the third consecutive read-strobe cycle
   assign b2.iRAM_DATA = (b2.oRAM_RD && rd_cnt == 2'd2) ? mem2[b2.oRAM_ADDR] : 32'hBAD0_BAD0;
   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask
   task automatic m0(input logic req, input logic wr, input logic lock, input logic [7:0] addr, input logic [31:0] wd);
      b0.iM0_REQ = req; b0.iM0_WR = wr; b0.iM0_LOCK = lock; b0.iM0_ADDR = addr; b0.iM0_WDATA = wd;
   endtask
   task automatic m1(input logic req, input logic wr, input logic lock, input logic [7:0] addr, input logic [31:0] wd);
      b0.iM1_REQ = req; b0.iM1_WR = wr; b0.iM1_LOCK = lock; b0.iM1_ADDR = addr; b0.iM1_WDATA = wd;
   endtask
   initial begin
      n_cmp = 0;
      n_err = 0;
      iRST  = 1'b1;
      m0(0, 0, 0, 8'h00, 32'h0);
      m1(0, 0, 0, 8'h00, 32'h0);
      b2.iM0_REQ = 0; b2.iM0_WR = 0; b2.iM0_LOCK = 0; b2.iM0_ADDR = '0; b2.iM0_WDATA = '0;
      b2.iM1_REQ = 0; b2.iM1_WR = 0; b2.iM1_LOCK = 0; b2.iM1_ADDR = '0; b2.iM1_WDATA = '0;
      #1 iRST = 1'b0;
      tick();
      tick();
      chk("rst_gnt", 32'(b0.oGNT), 0);
      chk("rst_busy", 32'(b0.oBUSY), 0);
      chk("rst_ce", 32'(b0.oRAM_CE), 0);
      chk("rst_ack0", 32'(b0.oM0_ACK), 0);
      chk("rst_rdata", b0.oM0_RDATA, 0);
      chk("rst_addr", 32'(b0.oRAM_ADDR), 0);
      chk("rst_data", b0.oRAM_DATA, 0);
      chk("rst_busy2", 32'(b2.oBUSY), 0);
      iRST = 1'b1;
      tick();
      m0(1, 1, 0, 8'h10, 32'hDEAD_BEEF);
      tick();
      chk("wr_ce", 32'(b0.oRAM_CE), 1);
      chk("wr_wr", 32'(b0.oRAM_WR), 1);
      chk("wr_rd", 32'(b0.oRAM_RD), 0);
      chk("wr_addr", 32'(b0.oRAM_ADDR), 32'h10);
      chk("wr_data", b0.oRAM_DATA, 32'hDEAD_BEEF);
      chk("wr_gnt", 32'(b0.oGNT), 1);
      chk("wr_ack_early", 32'(b0.oM0_ACK), 0);
      tick();
      chk("wr_ack", 32'(b0.oM0_ACK), 1);
      chk("wr_wr_off", 32'(b0.oRAM_WR), 0);
      chk("wr_ce_off", 32'(b0.oRAM_CE), 0);
      chk("wr_rdata", b0.oM0_RDATA, 0);
      m0(0, 0, 0, 8'h00, 32'h0);
      tick();
      chk("wr_idle_ack", 32'(b0.oM0_ACK), 0);
      chk("wr_idle_gnt", 32'(b0.oGNT), 0);
      chk("wr_idle_busy", 32'(b0.oBUSY), 0);
      m0(1, 0, 0, 8'h10, 32'h0);
      tick();
      chk("rd_rd", 32'(b0.oRAM_RD), 1);
      chk("rd_wr", 32'(b0.oRAM_WR), 0);
      tick();
      chk("rd_ack", 32'(b0.oM0_ACK), 1);
      chk("rd_rdata", b0.oM0_RDATA, 32'hDEAD_BEEF);
      m0(0, 0, 0, 8'h00, 32'h0);
      tick();
      m0(1, 0, 0, 8'h01, 32'h0);
      m1(1, 0, 0, 8'h02, 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("ct_gnt%0d", i), 32'(b0.oGNT), (i % 2 == 0) ? 32'd2 : 32'd1);
         tick();
         chk($sformatf("ct_ack0_%0d", i), 32'(b0.oM0_ACK), 32'(i % 2));
         chk($sformatf("ct_ack1_%0d", i), 32'(b0.oM1_ACK), 32'(1 - i % 2));
         chk($sformatf("ct_rdata%0d", i), (i % 2 == 1) ? b0.oM0_RDATA : b0.oM1_RDATA,
             (i % 2 == 1) ? 32'h1111_1111 : 32'h2222_2222);
         tick();
         chk($sformatf("ct_idle%0d", i), 32'(b0.oGNT), 0);
      end
      m0(0, 0, 0, 8'h00, 32'h0);
      m1(0, 0, 0, 8'h00, 32'h0);
      tick();
      m0(1, 0, 0, 8'h21, 32'h0);
      for (int k = 0; k < 3; k++) begin
         m1(1, 1, k < 2, 8'(8'h20 + k), 32'(32'hA0 + k));
         tick();
         chk($sformatf("lk_gnt%0d", k), 32'(b0.oGNT), 2);
         chk($sformatf("lk_addr%0d", k), 32'(b0.oRAM_ADDR), 32'(32'h20 + k));
         tick();
         chk($sformatf("lk_ack1_%0d", k), 32'(b0.oM1_ACK), 1);
         chk($sformatf("lk_ack0_%0d", k), 32'(b0.oM0_ACK), 0);
         if (k == 2) m1(0, 0, 0, 8'h00, 32'h0);
         tick();
         chk($sformatf("lk_hold%0d", k), 32'(b0.oGNT), (k < 2) ? 32'd2 : 32'd0);
      end
      tick();
      chk("lk_m0_gnt", 32'(b0.oGNT), 1);
      chk("lk_m0_addr", 32'(b0.oRAM_ADDR), 32'h21);
      tick();
      chk("lk_m0_ack", 32'(b0.oM0_ACK), 1);
      chk("lk_m0_rdata", b0.oM0_RDATA, 32'hA1);
      m0(0, 0, 0, 8'h00, 32'h0);
      tick();
      m0(1, 1, 0, 8'h30, 32'h55);
      tick();
      chk("rs_wr", 32'(b0.oRAM_WR), 1);
      #1 iRST = 1'b0;
      #1;
      chk("rs_wr_drop", 32'(b0.oRAM_WR), 0);
      chk("rs_ce_drop", 32'(b0.oRAM_CE), 0);
      chk("rs_gnt_drop", 32'(b0.oGNT), 0);
      chk("rs_busy_drop", 32'(b0.oBUSY), 0);
      m0(0, 0, 0, 8'h00, 32'h0);
      tick();
      chk("rs_noack", 32'(b0.oM0_ACK), 0);
      chk("rs_nowrite", mem0[8'h30], 0);
      iRST = 1'b1;
      tick();
      m0(1, 0, 0, 8'h10, 32'h0);
      m1(1, 0, 0, 8'h02, 32'h0);
      tick();
      chk("tie_gnt", 32'(b0.oGNT), 1);
      tick();
      chk("tie_ack0", 32'(b0.oM0_ACK), 1);
      chk("tie_ack1", 32'(b0.oM1_ACK), 0);
      chk("tie_rdata", b0.oM0_RDATA, 32'hDEAD_BEEF);
      m0(0, 0, 0, 8'h00, 32'h0);
      m1(0, 0, 0, 8'h00, 32'h0);
      tick();
      b2.iM1_REQ = 1; b2.iM1_WR = 0; b2.iM1_ADDR = 8'h05;
      tick();
      chk("l2_rd_acc", 32'(b2.oRAM_RD), 1);
      chk("l2_gnt", 32'(b2.oGNT), 2);
      chk("l2_ack_acc", 32'(b2.oM1_ACK), 0);
      tick();
      chk("l2_rd_w1", 32'(b2.oRAM_RD), 1);
      chk("l2_ce_w1", 32'(b2.oRAM_CE), 1);
      chk("l2_ack_w1", 32'(b2.oM1_ACK), 0);
      tick();
      chk("l2_rd_w2", 32'(b2.oRAM_RD), 1);
      chk("l2_ack_w2", 32'(b2.oM1_ACK), 0);
      tick();
      chk("l2_ack", 32'(b2.oM1_ACK), 1);
      chk("l2_rdata", b2.oM1_RDATA, 32'h1234_5678);
      chk("l2_rd_off", 32'(b2.oRAM_RD), 0);
      b2.iM1_REQ = 0;
      tick();
      chk("l2_idle", 32'(b2.oBUSY), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
